// File: rtl/beamformer_combiner_4.sv
// beamformer_combiner_4
//   Four-element complex combiner and LMS error generator. Holds the weight
//   bank, forms y = sum(conj(w_k) * x_k) through a 3-stage pipeline plus an
//   output register, and produces e = d - y for samples accepted in TRAIN.
//   The aligned x / w used for each sample are presented with y and e so the
//   external weight-update stage can close the loop.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                pulse: begin/restart a training window
//   in_valid, x*, d*     sample strobe, element samples, reference (Q1.16)
//   w_valid, w*_in*      updated weights from the weight-update stage
//   out_valid, y*, e*    combiner output and error (saturated Q1.16)
//   xd*, wd*             x and weights that produced this output
//   training, done       in TRAIN / one-cycle pulse on TRAIN -> HOLD
module beamformer_combiner_4 #(
  parameter int unsigned        TRAIN_LEN = 256,
  parameter logic signed [17:0] W_INIT    = 18'sd65536
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [17:0] x1I, x1Q, x2I, x2Q, x3I, x3Q, x4I, x4Q,
  input  logic signed [17:0] dI, dQ,
  input  logic               w_valid,
  input  logic signed [17:0] w1_inI, w1_inQ, w2_inI, w2_inQ,
  input  logic signed [17:0] w3_inI, w3_inQ, w4_inI, w4_inQ,
  output logic               out_valid,
  output logic signed [17:0] yI, yQ, eI, eQ,
  output logic signed [17:0] xd1I, xd1Q, xd2I, xd2Q, xd3I, xd3Q, xd4I, xd4Q,
  output logic signed [17:0] wd1I, wd1Q, wd2I, wd2Q, wd3I, wd3Q, wd4I, wd4Q,
  output logic               training,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, TRAIN, HOLD} state_t;

  localparam logic [15:0] LAST = 16'(TRAIN_LEN - 1);

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic        done_next;

  logic signed [17:0] x_i [4], x_q [4], w_in_i [4], w_in_q [4];
  logic signed [17:0] w_i [4], w_q [4];

  logic signed [17:0] s1_x_i [4], s1_x_q [4], s1_w_i [4], s1_w_q [4];
  logic signed [17:0] s1_d_i, s1_d_q;
  logic               s1_valid, s1_tag;

  logic signed [17:0] s2_x_i [4], s2_x_q [4], s2_w_i [4], s2_w_q [4];
  logic signed [19:0] s2_p_ii [4], s2_p_qq [4], s2_p_iq [4], s2_p_qi [4];
  logic signed [17:0] s2_d_i, s2_d_q;
  logic               s2_valid, s2_tag;

  logic signed [17:0] s3_x_i [4], s3_x_q [4], s3_w_i [4], s3_w_q [4];
  logic signed [21:0] s3_acc_i, s3_acc_q;
  logic signed [17:0] s3_d_i, s3_d_q;
  logic               s3_valid, s3_tag;

  logic signed [21:0] sum_i, sum_q;
  logic signed [17:0] y_sat_i, y_sat_q, e_sat_i, e_sat_q;
  logic signed [18:0] diff_i, diff_q;

  logic signed [17:0] xd_i [4], xd_q [4], wd_i [4], wd_q [4];

  // Full 36-bit product, arithmetic shift by 16, keep 20 bits.
  function automatic logic signed [19:0] mul_shift(input logic signed [17:0] a,
                                                   input logic signed [17:0] b);
    logic signed [35:0] p;
    p = a * b;
    return 20'(p >>> 16);
  endfunction

  function automatic logic signed [21:0] sext20(input logic signed [19:0] v);
    return {{2{v[19]}}, v};
  endfunction

  function automatic logic signed [17:0] sat22(input logic signed [21:0] v);
    if (v > 22'sd131071)       return 18'sd131071;
    else if (v < -22'sd131072) return 18'sh20000;
    else                       return v[17:0];
  endfunction

  function automatic logic signed [17:0] sat19(input logic signed [18:0] v);
    if (v > 19'sd131071)       return 18'sd131071;
    else if (v < -19'sd131072) return 18'sh20000;
    else                       return v[17:0];
  endfunction

  assign x_i[0] = x1I;  assign x_q[0] = x1Q;
  assign x_i[1] = x2I;  assign x_q[1] = x2Q;
  assign x_i[2] = x3I;  assign x_q[2] = x3Q;
  assign x_i[3] = x4I;  assign x_q[3] = x4Q;
  assign w_in_i[0] = w1_inI;  assign w_in_q[0] = w1_inQ;
  assign w_in_i[1] = w2_inI;  assign w_in_q[1] = w2_inQ;
  assign w_in_i[2] = w3_inI;  assign w_in_q[2] = w3_inQ;
  assign w_in_i[3] = w4_inI;  assign w_in_q[3] = w4_inQ;

  assign xd1I = xd_i[0];  assign xd1Q = xd_q[0];
  assign xd2I = xd_i[1];  assign xd2Q = xd_q[1];
  assign xd3I = xd_i[2];  assign xd3Q = xd_q[2];
  assign xd4I = xd_i[3];  assign xd4Q = xd_q[3];
  assign wd1I = wd_i[0];  assign wd1Q = wd_q[0];
  assign wd2I = wd_i[1];  assign wd2Q = wd_q[1];
  assign wd3I = wd_i[2];  assign wd3Q = wd_q[2];
  assign wd4I = wd_i[3];  assign wd4Q = wd_q[3];

  assign training = (state == TRAIN);

  // start has priority over the final sample, so a restart on the
  // TRAIN_LEN-th acceptance suppresses the HOLD transition and done.
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = TRAIN;
          count_next = '0;
        end
      end
      TRAIN: begin
        if (start) begin
          count_next = '0;
        end else if (in_valid) begin
          if (count == LAST) begin
            state_next = HOLD;
            count_next = '0;
            done_next  = 1'b1;
          end else begin
            count_next = count + 16'd1;
          end
        end
      end
      HOLD: begin
        if (start) begin
          state_next = TRAIN;
          count_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
    end
  end

  // Weight bank: only TRAIN accepts updates; IDLE pins the initial bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        w_i[k] <= (k == 0) ? W_INIT : '0;
        w_q[k] <= '0;
      end
    end else if (state == IDLE) begin
      for (int k = 0; k < 4; k++) begin
        w_i[k] <= (k == 0) ? W_INIT : '0;
        w_q[k] <= '0;
      end
    end else if (state == TRAIN && w_valid) begin
      for (int k = 0; k < 4; k++) begin
        w_i[k] <= w_in_i[k];
        w_q[k] <= w_in_q[k];
      end
    end
  end

  // Stage 1 captures the bank before any same-edge update, and tags the
  // sample with the state it was accepted in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s1_d_i   <= '0;
      s1_d_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        s1_x_i[k] <= '0;  s1_x_q[k] <= '0;
        s1_w_i[k] <= '0;  s1_w_q[k] <= '0;
      end
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_tag <= (state == TRAIN);
        s1_d_i <= dI;
        s1_d_q <= dQ;
        for (int k = 0; k < 4; k++) begin
          s1_x_i[k] <= x_i[k];  s1_x_q[k] <= x_q[k];
          s1_w_i[k] <= w_i[k];  s1_w_q[k] <= w_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
      s2_d_i   <= '0;
      s2_d_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        s2_x_i[k]  <= '0;  s2_x_q[k]  <= '0;
        s2_w_i[k]  <= '0;  s2_w_q[k]  <= '0;
        s2_p_ii[k] <= '0;  s2_p_qq[k] <= '0;
        s2_p_iq[k] <= '0;  s2_p_qi[k] <= '0;
      end
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_tag <= s1_tag;
        s2_d_i <= s1_d_i;
        s2_d_q <= s1_d_q;
        for (int k = 0; k < 4; k++) begin
          s2_x_i[k]  <= s1_x_i[k];  s2_x_q[k] <= s1_x_q[k];
          s2_w_i[k]  <= s1_w_i[k];  s2_w_q[k] <= s1_w_q[k];
          s2_p_ii[k] <= mul_shift(s1_w_i[k], s1_x_i[k]);
          s2_p_qq[k] <= mul_shift(s1_w_q[k], s1_x_q[k]);
          s2_p_iq[k] <= mul_shift(s1_w_i[k], s1_x_q[k]);
          s2_p_qi[k] <= mul_shift(s1_w_q[k], s1_x_i[k]);
        end
      end
    end
  end

  // Conjugate weighting: yI = sum(wI*xI + wQ*xQ), yQ = sum(wI*xQ - wQ*xI).
  always_comb begin
    sum_i = '0;
    sum_q = '0;
    for (int k = 0; k < 4; k++) begin
      sum_i = sum_i + sext20(s2_p_ii[k]) + sext20(s2_p_qq[k]);
      sum_q = sum_q + sext20(s2_p_iq[k]) - sext20(s2_p_qi[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_tag   <= 1'b0;
      s3_acc_i <= '0;
      s3_acc_q <= '0;
      s3_d_i   <= '0;
      s3_d_q   <= '0;
      for (int k = 0; k < 4; k++) begin
        s3_x_i[k] <= '0;  s3_x_q[k] <= '0;
        s3_w_i[k] <= '0;  s3_w_q[k] <= '0;
      end
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_tag   <= s2_tag;
        s3_acc_i <= sum_i;
        s3_acc_q <= sum_q;
        s3_d_i   <= s2_d_i;
        s3_d_q   <= s2_d_q;
        for (int k = 0; k < 4; k++) begin
          s3_x_i[k] <= s2_x_i[k];  s3_x_q[k] <= s2_x_q[k];
          s3_w_i[k] <= s2_w_i[k];  s3_w_q[k] <= s2_w_q[k];
        end
      end
    end
  end

  // Error is taken against the saturated y, widened by one bit so d - y
  // cannot wrap before clamping.
  always_comb begin
    y_sat_i = sat22(s3_acc_i);
    y_sat_q = sat22(s3_acc_q);
    diff_i  = {s3_d_i[17], s3_d_i} - {y_sat_i[17], y_sat_i};
    diff_q  = {s3_d_q[17], s3_d_q} - {y_sat_q[17], y_sat_q};
    e_sat_i = sat19(diff_i);
    e_sat_q = sat19(diff_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      yI <= '0;  yQ <= '0;
      eI <= '0;  eQ <= '0;
      for (int k = 0; k < 4; k++) begin
        xd_i[k] <= '0;  xd_q[k] <= '0;
        wd_i[k] <= '0;  wd_q[k] <= '0;
      end
    end else begin
      out_valid <= s3_valid;
      if (s3_valid) begin
        yI <= y_sat_i;
        yQ <= y_sat_q;
        eI <= s3_tag ? e_sat_i : 18'sd0;
        eQ <= s3_tag ? e_sat_q : 18'sd0;
        for (int k = 0; k < 4; k++) begin
          xd_i[k] <= s3_x_i[k];  xd_q[k] <= s3_x_q[k];
          wd_i[k] <= s3_w_i[k];  wd_q[k] <= s3_w_q[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_beamformer_combiner_4.sv
// tb_beamformer_combiner_4
//   Self-checking bench for beamformer_combiner_4 (TRAIN_LEN = 4). Stimulus
//   pushes expected results from a behavioural model into a queue; a monitor
//   pops and compares whenever out_valid is seen.
module tb_beamformer_combiner_4;

  localparam int     TLEN     = 4;
  localparam longint W_INIT_V = 65536;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic w_valid = 1'b0;
  logic signed [17:0] x_i [4], x_q [4], w_in_i [4], w_in_q [4];
  logic signed [17:0] d_i, d_q;

  logic               out_valid, training, done;
  logic signed [17:0] yI, yQ, eI, eQ;
  logic signed [17:0] xd_i [4], xd_q [4], wd_i [4], wd_q [4];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic signed [17:0] y_i, y_q, e_i, e_q;
    logic [3:0][17:0]   x_i, x_q, w_i, w_q;
  } exp_t;

  exp_t exp_q [$];
  exp_t cur;

  int     m_state;
  int     m_count;
  bit     m_done;
  longint m_wi [4], m_wq [4];

  beamformer_combiner_4 #(.TRAIN_LEN(TLEN), .W_INIT(18'sd65536)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .x1I(x_i[0]), .x1Q(x_q[0]), .x2I(x_i[1]), .x2Q(x_q[1]),
    .x3I(x_i[2]), .x3Q(x_q[2]), .x4I(x_i[3]), .x4Q(x_q[3]),
    .dI(d_i), .dQ(d_q), .w_valid(w_valid),
    .w1_inI(w_in_i[0]), .w1_inQ(w_in_q[0]), .w2_inI(w_in_i[1]), .w2_inQ(w_in_q[1]),
    .w3_inI(w_in_i[2]), .w3_inQ(w_in_q[2]), .w4_inI(w_in_i[3]), .w4_inQ(w_in_q[3]),
    .out_valid(out_valid), .yI(yI), .yQ(yQ), .eI(eI), .eQ(eQ),
    .xd1I(xd_i[0]), .xd1Q(xd_q[0]), .xd2I(xd_i[1]), .xd2Q(xd_q[1]),
    .xd3I(xd_i[2]), .xd3Q(xd_q[2]), .xd4I(xd_i[3]), .xd4Q(xd_q[3]),
    .wd1I(wd_i[0]), .wd1Q(wd_q[0]), .wd2I(wd_i[1]), .wd2Q(wd_q[1]),
    .wd3I(wd_i[2]), .wd3Q(wd_q[2]), .wd4I(wd_i[3]), .wd4Q(wd_q[3]),
    .training(training), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input longint act, input longint req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint clamp18(input longint v);
    if (v > 131071)  return 131071;
    if (v < -131072) return -131072;
    return v;
  endfunction

  function automatic longint wrap22(input longint v);
    longint t;
    t = v & 64'h3FFFFF;
    if (t >= 64'sd2097152) t = t - 64'sd4194304;
    return t;
  endfunction

  function automatic void resetModel();
    m_state = 0;
    m_count = 0;
    m_done  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_wi[k] = (k == 0) ? W_INIT_V : 0;
      m_wq[k] = 0;
    end
  endfunction

  // y = sum(conj(w) * x) with each product scaled by 2^-16 (floor), the
  // sum held in 22 bits, then clamped; e = clamp(d - y) only for TRAIN tags.
  function automatic void pushExpected();
    exp_t   e;
    longint si, sq, yi, yq;
    si = 0;
    sq = 0;
    for (int k = 0; k < 4; k++) begin
      si += ((m_wi[k] * longint'(x_i[k])) >>> 16) + ((m_wq[k] * longint'(x_q[k])) >>> 16);
      sq += ((m_wi[k] * longint'(x_q[k])) >>> 16) - ((m_wq[k] * longint'(x_i[k])) >>> 16);
    end
    yi = clamp18(wrap22(si));
    yq = clamp18(wrap22(sq));
    e.y_i = 18'(yi);
    e.y_q = 18'(yq);
    e.e_i = (m_state == 1) ? 18'(clamp18(longint'(d_i) - yi)) : 18'sd0;
    e.e_q = (m_state == 1) ? 18'(clamp18(longint'(d_q) - yq)) : 18'sd0;
    for (int k = 0; k < 4; k++) begin
      e.x_i[k] = x_i[k];
      e.x_q[k] = x_q[k];
      e.w_i[k] = 18'(m_wi[k]);
      e.w_q[k] = 18'(m_wq[k]);
    end
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input bit st, input bit iv, input bit wv);
    @(negedge clk);
    start    = st;
    in_valid = iv;
    w_valid  = wv;
    if (iv) pushExpected();
    m_done = 1'b0;
    if (wv && m_state == 1) begin
      for (int k = 0; k < 4; k++) begin
        m_wi[k] = w_in_i[k];
        m_wq[k] = w_in_q[k];
      end
    end
    case (m_state)
      0: if (st) begin m_state = 1; m_count = 0; end
      1: begin
        if (st) m_count = 0;
        else if (iv) begin
          m_count++;
          if (m_count == TLEN) begin
            m_state = 2;
            m_count = 0;
            m_done  = 1'b1;
          end
        end
      end
      2: if (st) begin m_state = 1; m_count = 0; end
      default: m_state = 0;
    endcase
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    w_valid  = 1'b0;
    checkOutput("training", longint'(training), longint'(m_state == 1));
    checkOutput("done", longint'(done), longint'(m_done));
  endtask

  task automatic setX(input int k, input longint vi, input longint vq);
    x_i[k] = 18'(vi);
    x_q[k] = 18'(vq);
  endtask

  task automatic setW(input int k, input longint vi, input longint vq);
    w_in_i[k] = 18'(vi);
    w_in_q[k] = 18'(vq);
  endtask

  task automatic clearData();
    for (int k = 0; k < 4; k++) begin
      setX(k, 0, 0);
      setW(k, 0, 0);
    end
    d_i = '0;
    d_q = '0;
  endtask

  task automatic randomData();
    for (int k = 0; k < 4; k++) begin
      x_i[k] = 18'($urandom);  x_q[k] = 18'($urandom);
      w_in_i[k] = 18'($urandom);  w_in_q[k] = 18'($urandom);
    end
    d_i = 18'($urandom);
    d_q = 18'($urandom);
  endtask

  // Monitor: every out_valid must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL unexpected_out_valid: got 1, expected 0");
      end else begin
        cur = exp_q.pop_front();
        checkOutput("yI", longint'(yI), longint'(cur.y_i));
        checkOutput("yQ", longint'(yQ), longint'(cur.y_q));
        checkOutput("eI", longint'(eI), longint'(cur.e_i));
        checkOutput("eQ", longint'(eQ), longint'(cur.e_q));
        for (int k = 0; k < 4; k++) begin
          checkOutput($sformatf("xd%0dI", k + 1), longint'(xd_i[k]), longint'($signed(cur.x_i[k])));
          checkOutput($sformatf("xd%0dQ", k + 1), longint'(xd_q[k]), longint'($signed(cur.x_q[k])));
          checkOutput($sformatf("wd%0dI", k + 1), longint'(wd_i[k]), longint'($signed(cur.w_i[k])));
          checkOutput($sformatf("wd%0dQ", k + 1), longint'(wd_q[k]), longint'($signed(cur.w_q[k])));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearData();
    resetModel();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", longint'(out_valid), 0);
    checkOutput("rst_training", longint'(training), 0);
    checkOutput("rst_done", longint'(done), 0);
    checkOutput("rst_yI", longint'(yI), 0);
    checkOutput("rst_eI", longint'(eI), 0);
    checkOutput("rst_wd1I", longint'(wd_i[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through in IDLE: e forced to 0, wd1 = W_INIT.
    setX(0, 32768, 16384);
    d_i = 18'sd1234;
    d_q = -18'sd77;
    applyStimulus(0, 1, 0);

    // Same-edge weight load is not seen by that sample; then conjugate product.
    clearData();
    applyStimulus(1, 0, 0);
    setW(0, 0, 65536);
    setX(0, 65536, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);

    // Saturation of y and e.
    for (int k = 0; k < 4; k++) begin
      setW(k, 131071, 0);
      setX(k, 131071, 0);
    end
    applyStimulus(0, 0, 1);
    d_i = -18'sd131072;
    d_q = '0;
    applyStimulus(0, 1, 0);

    // Training window of 4 with 6 samples; then w_valid ignored in HOLD.
    applyStimulus(1, 0, 0);
    clearData();
    setW(0, 65536, 0);
    applyStimulus(0, 0, 1);
    setX(0, 32768, 0);
    d_i = 18'sd65536;
    repeat (6) applyStimulus(0, 1, 0);
    for (int k = 0; k < 4; k++) setW(k, 5000 + k, -3000 - k);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);

    // start coincident with the final sample: start wins, no done.
    applyStimulus(1, 0, 0);
    repeat (3) applyStimulus(0, 1, 0);
    applyStimulus(1, 1, 0);
    repeat (4) applyStimulus(0, 1, 0);

    // Randomized traffic.
    repeat (400) begin
      randomData();
      applyStimulus(($urandom % 16) == 0, ($urandom % 10) < 7, ($urandom % 5) == 0);
    end

    // Reset with three samples in flight and a non-initial weight bank.
    applyStimulus(1, 0, 0);
    randomData();
    setW(0, 1000, 2000);
    applyStimulus(0, 0, 1);
    repeat (3) begin
      randomData();
      applyStimulus(0, 1, 0);
    end
    #2;
    rst_n    = 1'b0;
    exp_q.delete();
    resetModel();
    #1;
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_yI", longint'(yI), 0);
    checkOutput("midrst_eQ", longint'(eQ), 0);
    checkOutput("midrst_wd1I", longint'(wd_i[0]), 0);
    checkOutput("midrst_training", longint'(training), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrst_hold_out_valid", longint'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    randomData();
    applyStimulus(0, 1, 0);
    clearData();
    repeat (6) applyStimulus(0, 0, 0);
    checkOutput("drain_queue_empty", longint'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
